// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory port B arbiter: FSM states, one-cycle strobes
// and the register reset values.
package memory_arbiter_pkg;

  localparam int STARVE_CNT_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CPU_WR = 3'd1,
    CPU_RA = 3'd2,
    CPU_RD = 3'd3,
    DEV_WR = 3'd4,
    DEV_RA = 3'd5,
    DEV_RD = 3'd6
  } state_t;

  // Every flag here is high for exactly one cycle per access.
  typedef struct packed {
    logic write_enable;
    logic row_write;
    logic cpu_ack;
    logic dev_ack;
  } strobes_t;

  localparam state_t   STATE_DEFAULT   = IDLE;
  localparam strobes_t STROBES_DEFAULT = '0;

endpackage

// File: rtl/memory_arbiter_fairness.sv
// Starvation counter and winner select for the port B arbiter; the device wins
// once the CPU has taken STARVE_LIMIT grants while the device was waiting.
module memory_arbiter_fairness
  import memory_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic cpu_req,
  input  logic dev_req,
  input  logic grant_event,
  output logic dev_wins
);

  localparam logic [STARVE_CNT_WIDTH-1:0] LIMIT = STARVE_CNT_WIDTH'(STARVE_LIMIT);

  logic [STARVE_CNT_WIDTH-1:0] starve_cnt;

  assign dev_wins = dev_req && (!cpu_req || starve_cnt == LIMIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (grant_event) begin
      if (dev_wins)
        starve_cnt <= '0;
      else if (dev_req && starve_cnt < LIMIT)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/memory_port_b_arbiter.sv
// Shares memory port B between CPU word accesses and device row transfers,
// with registered memory controls and one-shot acknowledges.
module memory_port_b_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int ROW_WIDTH    = 256,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic                  cpu_write,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_data_in,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_data_out,
  input  logic                  dev_req,
  input  logic                  dev_write,
  input  logic [ADDR_WIDTH-1:0] dev_addr,
  input  logic [ROW_WIDTH-1:0]  dev_row_in,
  output logic                  dev_ack,
  output logic [ROW_WIDTH-1:0]  dev_row_out,
  output logic                  mem_write_enable,
  output logic                  mem_row_write,
  output logic [ADDR_WIDTH-1:0] mem_portB_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [ROW_WIDTH-1:0]  mem_row_data,
  input  logic [DATA_WIDTH-1:0] mem_portB_out,
  input  logic [ROW_WIDTH-1:0]  mem_row_data_out,
  output logic                  busy
);

  state_t   state;
  strobes_t strobes;
  logic     grant_event;
  logic     dev_wins;

  assign grant_event = (state == IDLE) && (cpu_req || dev_req);
  assign busy        = (state != IDLE);

  assign mem_write_enable = strobes.write_enable;
  assign mem_row_write    = strobes.row_write;
  assign cpu_ack          = strobes.cpu_ack;
  assign dev_ack          = strobes.dev_ack;

  memory_arbiter_fairness #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_fairness (
    .clock      (clock),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .dev_req    (dev_req),
    .grant_event(grant_event),
    .dev_wins   (dev_wins)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= STATE_DEFAULT;
      strobes           <= STROBES_DEFAULT;
      mem_portB_address <= '0;
      mem_data_in       <= '0;
      mem_row_data      <= '0;
      cpu_data_out      <= '0;
      dev_row_out       <= '0;
    end else begin
      strobes <= STROBES_DEFAULT;
      case (state)
        IDLE: begin
          if (dev_wins) begin
            mem_portB_address <= dev_addr;
            if (dev_write) begin
              mem_row_data      <= dev_row_in;
              strobes.row_write <= 1'b1;
              strobes.dev_ack   <= 1'b1;
              state             <= DEV_WR;
            end else begin
              state <= DEV_RA;
            end
          end else if (cpu_req) begin
            mem_portB_address <= cpu_addr;
            if (cpu_write) begin
              mem_data_in          <= cpu_data_in;
              strobes.write_enable <= 1'b1;
              strobes.cpu_ack      <= 1'b1;
              state                <= CPU_WR;
            end else begin
              state <= CPU_RA;
            end
          end
        end
        // Read data becomes valid one cycle after the address, so capture here.
        CPU_RA: begin
          cpu_data_out    <= mem_portB_out;
          strobes.cpu_ack <= 1'b1;
          state           <= CPU_RD;
        end
        DEV_RA: begin
          dev_row_out     <= mem_row_data_out;
          strobes.dev_ack <= 1'b1;
          state           <= DEV_RD;
        end
        CPU_WR, CPU_RD, DEV_WR, DEV_RD: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_port_b_arbiter.sv
// Bench for memory_port_b_arbiter: directed and randomized traffic against a
// cycle-occupancy arbitration model and a reference copy of memory.
module tb_memory_port_b_arbiter;

  localparam int STARVE_LIMIT = 4;

  typedef struct {
    bit           wr;
    logic [15:0]  addr;
    logic [255:0] data;
  } op_t;

  logic         clock;
  logic         reset_n;
  logic         cpu_req, cpu_write, cpu_ack;
  logic [15:0]  cpu_addr, cpu_data_in, cpu_data_out;
  logic         dev_req, dev_write, dev_ack;
  logic [15:0]  dev_addr;
  logic [255:0] dev_row_in, dev_row_out;
  logic         mem_write_enable, mem_row_write, busy;
  logic [15:0]  mem_portB_address, mem_data_in, mem_portB_out;
  logic [255:0] mem_row_data, mem_row_data_out;

  logic [15:0]  mem     [65536];
  logic [15:0]  ref_mem [65536];

  int  n_tests = 0;
  int  n_fail  = 0;
  int  starve  = 0;
  int  cpu_before_dev;
  bit  dev_seen;
  bit  cpu_inflight = 0;
  bit  dev_inflight = 0;
  op_t cpu_q[$];
  op_t dev_q[$];

  memory_port_b_arbiter #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .ROW_WIDTH(256), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_data_in(cpu_data_in), .cpu_ack(cpu_ack), .cpu_data_out(cpu_data_out),
    .dev_req(dev_req), .dev_write(dev_write), .dev_addr(dev_addr),
    .dev_row_in(dev_row_in), .dev_ack(dev_ack), .dev_row_out(dev_row_out),
    .mem_write_enable(mem_write_enable), .mem_row_write(mem_row_write),
    .mem_portB_address(mem_portB_address), .mem_data_in(mem_data_in),
    .mem_row_data(mem_row_data), .mem_portB_out(mem_portB_out),
    .mem_row_data_out(mem_row_data_out), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory device: rows are the 16 words sharing addr[15:4]; writes commit on the edge.
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    forever begin
      @(posedge clock);
      if (mem_write_enable) mem[mem_portB_address] = mem_data_in;
      if (mem_row_write)
        for (int i = 0; i < 16; i++)
          mem[{mem_portB_address[15:4], 4'(i)}] = mem_row_data[16*i +: 16];
    end
  end

  assign mem_portB_out = mem[mem_portB_address];

  always_comb begin
    mem_row_data_out = '0;
    for (int i = 0; i < 16; i++)
      mem_row_data_out[16*i +: 16] = mem[{mem_portB_address[15:4], 4'(i)}];
  end

  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      n_tests++;
      assert (!(mem_write_enable === 1'b1 && mem_row_write === 1'b1)) else begin
        n_fail++;
        $error("FAIL enables_exclusive: observed both high, expected at most one");
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] ref_row(input logic [15:0] a);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[16*i +: 16] = ref_mem[{a[15:4], 4'(i)}];
    return r;
  endfunction

  function automatic op_t mk_op(input bit wr, input logic [15:0] a, input logic [255:0] d);
    op_t o;
    o.wr = wr; o.addr = a; o.data = d;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.wr   = 1'($urandom_range(0, 1));
    o.addr = ($urandom_range(0, 9) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15)))
                                         : 16'($urandom_range(0, 47));
    for (int i = 0; i < 8; i++) o.data[32*i +: 32] = $urandom();
    return o;
  endfunction

  task automatic present_reqs(input bit rnd);
    if (!cpu_req && !cpu_inflight && cpu_q.size() != 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
      cpu_req = 1'b1; cpu_write = cpu_q[0].wr;
      cpu_addr = cpu_q[0].addr; cpu_data_in = cpu_q[0].data[15:0];
    end
    if (!dev_req && !dev_inflight && dev_q.size() != 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
      dev_req = 1'b1; dev_write = dev_q[0].wr;
      dev_addr = dev_q[0].addr; dev_row_in = dev_q[0].data;
    end
  endtask

  // Model: the port is granted at an edge once the previous access has had its
  // ack edge plus one IDLE cycle; writes ack at the grant edge, reads one later.
  task automatic run_traffic(input bit rnd);
    int           e = 0;
    int           busy_until = -1;
    bit           grant_now;
    bit           g_cpu = 1'b0;
    op_t          g;
    logic [255:0] exp_rd = '0;
    g = mk_op(1'b0, 16'h0, '0);
    cpu_before_dev = 0;
    dev_seen = 1'b0;
    present_reqs(rnd);
    while ((cpu_q.size() != 0 || dev_q.size() != 0 || e <= busy_until) && e < 4000) begin
      @(posedge clock);
      e++;
      grant_now = 1'b0;
      if (e >= busy_until + 2 && (cpu_req || dev_req)) begin
        grant_now = 1'b1;
        g_cpu = !(dev_req && (!cpu_req || starve == STARVE_LIMIT));
        if (g_cpu) begin
          g = cpu_q[0]; cpu_inflight = 1'b1;
          if (dev_req && starve < STARVE_LIMIT) starve++;
        end else begin
          g = dev_q[0]; dev_inflight = 1'b1; starve = 0;
        end
        busy_until = e + (g.wr ? 0 : 1);
        if (g_cpu && g.wr) ref_mem[g.addr] = g.data[15:0];
        else if (g_cpu) exp_rd = {240'd0, ref_mem[g.addr]};
        else if (g.wr) for (int i = 0; i < 16; i++) ref_mem[{g.addr[15:4], 4'(i)}] = g.data[16*i +: 16];
        else exp_rd = ref_row(g.addr);
      end
      @(negedge clock);
      check("cpu_ack", cpu_ack, (e == busy_until) && g_cpu);
      check("dev_ack", dev_ack, (e == busy_until) && !g_cpu);
      check("busy", busy, e <= busy_until);
      check("mem_write_enable", mem_write_enable, grant_now && g_cpu && g.wr);
      check("mem_row_write", mem_row_write, grant_now && !g_cpu && g.wr);
      if (grant_now) begin
        check("mem_portB_address", mem_portB_address, g.addr);
        if (g.wr && g_cpu) check("mem_data_in", mem_data_in, g.data[15:0]);
        if (g.wr && !g_cpu) check("mem_row_data", mem_row_data, g.data);
      end
      if (e == busy_until && !g.wr) begin
        if (g_cpu) check("cpu_data_out", cpu_data_out, exp_rd[15:0]);
        else       check("dev_row_out", dev_row_out, exp_rd);
      end
      if (cpu_ack === 1'b1 && !dev_seen) cpu_before_dev++;
      if (dev_ack === 1'b1) dev_seen = 1'b1;
      if (e == busy_until) begin
        if (g_cpu) begin void'(cpu_q.pop_front()); cpu_inflight = 1'b0; cpu_req = 1'b0; end
        else       begin void'(dev_q.pop_front()); dev_inflight = 1'b0; dev_req = 1'b0; end
      end else if (grant_now && rnd && $urandom_range(0, 3) == 0) begin
        if (g_cpu) cpu_req = 1'b0;
        else       dev_req = 1'b0;
      end
      present_reqs(rnd);
    end
    check("queue_drained", cpu_q.size() + dev_q.size(), 0);
    check("starve_cnt", dut.u_fairness.starve_cnt, starve);
  endtask

  initial begin
    logic [255:0] pat;
    pat = {16{16'hA5A5}};
    for (int i = 0; i < 65536; i++) ref_mem[i] = 16'h0000;
    reset_n = 1'b0;
    cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_data_in = '0;
    dev_req = 1'b0; dev_write = 1'b0; dev_addr = '0; dev_row_in = '0;
    repeat (2) @(negedge clock);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_dev_ack", dev_ack, 0);
    check("rst_mem_write_enable", mem_write_enable, 0);
    check("rst_mem_row_write", mem_row_write, 0);
    check("rst_address", mem_portB_address, 0);
    check("rst_busy", busy, 0);
    check("rst_cpu_data_out", cpu_data_out, 0);
    check("rst_dev_row_out", dev_row_out, 0);
    reset_n = 1'b1;

    cpu_q.push_back(mk_op(1'b1, 16'h0005, 256'h1234));
    cpu_q.push_back(mk_op(1'b0, 16'h0005, '0));
    run_traffic(1'b0);

    dev_q.push_back(mk_op(1'b1, 16'h0040, pat));
    dev_q.push_back(mk_op(1'b0, 16'h0040, '0));
    run_traffic(1'b0);

    cpu_q.push_back(mk_op(1'b0, 16'h0005, '0));
    dev_q.push_back(mk_op(1'b0, 16'h0040, '0));
    run_traffic(1'b0);
    check("simultaneous_cpu_first", cpu_before_dev, 1);

    cpu_q.push_back(mk_op(1'b1, 16'hFFFF, 256'hBEEF));
    dev_q.push_back(mk_op(1'b0, 16'hFFFC, '0));
    run_traffic(1'b0);

    cpu_q.push_back(mk_op(1'b1, 16'h0077, 256'h1111));
    run_traffic(1'b0);
    cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 16'h0077; cpu_data_in = 16'h2222;
    @(posedge clock); #1;
    check("pre_reset_write_enable", mem_write_enable, 1);
    #1 reset_n = 1'b0;
    #1;
    check("reset_write_enable_drop", mem_write_enable, 0);
    check("reset_no_cpu_ack", cpu_ack, 0);
    check("reset_busy", busy, 0);
    cpu_req = 1'b0;
    starve = 0;
    @(negedge clock);
    @(negedge clock);
    check("reset_mem_unchanged", mem[16'h0077], 16'h1111);
    reset_n = 1'b1;
    cpu_q.push_back(mk_op(1'b0, 16'h0077, '0));
    run_traffic(1'b0);

    for (int i = 0; i < 6; i++) cpu_q.push_back(mk_op(1'b0, 16'(i), '0));
    dev_q.push_back(mk_op(1'b0, 16'h0040, '0));
    run_traffic(1'b0);
    check("starve_cpu_grants", cpu_before_dev, STARVE_LIMIT);

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 40; i++) begin
        cpu_q.push_back(rand_op());
        dev_q.push_back(rand_op());
      end
      run_traffic(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
